// File: rtl/sha256_bus_master.sv
// Autonomous bus initiator for the SHA-256 peripheral. It loads one 512-bit block,
// starts init/next, polls for completion and reads the 256-bit digest back.
module sha256_bus_master #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    POLL_LIMIT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_first_i,
  input  logic [511:0]          cmd_block_i,
  output logic [255:0]          digest_o,
  output logic                  digest_valid_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [63:0]           bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [63:0]           bus_rdata_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_DATA = 3'd1;
  localparam logic [2:0] S_WR_SET  = 3'd2;
  localparam logic [2:0] S_WR_CLR  = 3'd3;
  localparam logic [2:0] S_POLL    = 3'd4;
  localparam logic [2:0] S_RD_DIG  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  localparam int                POLL_W    = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);

  logic [2:0]            state;
  logic [3:0]            word_cnt;
  logic [POLL_W-1:0]     poll_cnt;
  logic [511:0]          block_q;
  logic                  first_q;
  logic                  wait_rv;

  logic                  tx_we;
  logic [4:0]            tx_idx;
  logic [63:0]           tx_wdata;
  logic [ADDR_WIDTH-1:0] tx_addr;
  logic                  tx_done;

  logic                  unused_rdata;
  assign unused_rdata = ^bus_rdata_i[63:32];

  assign cmd_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);

  // Transaction that the current state wants to issue next.
  always_comb begin
    tx_we    = 1'b0;
    tx_idx   = 5'd0;
    tx_wdata = 64'd0;
    case (state)
      S_WR_DATA: begin
        tx_we    = 1'b1;
        tx_idx   = {1'b0, word_cnt} + 5'd1;
        tx_wdata = {32'd0, block_q[{word_cnt, 5'd0} +: 32]};
      end
      S_WR_SET: begin
        tx_we    = 1'b1;
        tx_wdata = first_q ? 64'h1 : 64'h2;
      end
      S_WR_CLR: tx_we = 1'b1;
      S_POLL:   tx_idx = 5'd17;
      S_RD_DIG: tx_idx = 5'd18 + {2'b00, word_cnt[2:0]};
      default:  tx_idx = 5'd0;
    endcase
  end

  assign tx_addr = BASE_ADDR + ADDR_WIDTH'({tx_idx, 3'b000});
  assign tx_done = wait_rv ? bus_rvalid_i : (bus_req_o && bus_gnt_i && bus_rvalid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      word_cnt       <= 4'd0;
      poll_cnt       <= '0;
      block_q        <= '0;
      first_q        <= 1'b0;
      wait_rv        <= 1'b0;
      bus_req_o      <= 1'b0;
      bus_we_o       <= 1'b0;
      bus_addr_o     <= '0;
      bus_wdata_o    <= 64'd0;
      digest_o       <= '0;
      digest_valid_o <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      digest_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            // The first data write goes out straight from the accept cycle.
            state       <= S_WR_DATA;
            block_q     <= cmd_block_i;
            first_q     <= cmd_first_i;
            err_o       <= 1'b0;
            word_cnt    <= 4'd0;
            poll_cnt    <= '0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b1;
            bus_addr_o  <= BASE_ADDR + ADDR_WIDTH'(8);
            bus_wdata_o <= {32'd0, cmd_block_i[31:0]};
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERR: begin
          err_o <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          if (bus_req_o && bus_gnt_i) begin
            bus_req_o <= 1'b0;
            wait_rv   <= !bus_rvalid_i;
          end else if (wait_rv && bus_rvalid_i) begin
            wait_rv <= 1'b0;
          end else if (!bus_req_o && !wait_rv) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= tx_we;
            bus_addr_o  <= tx_addr;
            bus_wdata_o <= tx_wdata;
          end

          // Advance only once the outstanding transaction has completed.
          if (tx_done) begin
            case (state)
              S_WR_DATA: begin
                word_cnt <= word_cnt + 4'd1;
                if (word_cnt == 4'd15) state <= S_WR_SET;
              end
              S_WR_SET: state <= S_WR_CLR;
              S_WR_CLR: begin
                state    <= S_POLL;
                poll_cnt <= '0;
              end
              S_POLL: begin
                if (bus_rdata_i[0]) begin
                  state    <= S_RD_DIG;
                  word_cnt <= 4'd0;
                end else if (poll_cnt == POLL_LAST) begin
                  state <= S_ERR;
                end else begin
                  poll_cnt <= poll_cnt + POLL_W'(1);
                end
              end
              S_RD_DIG: begin
                digest_o[{word_cnt[2:0], 5'd0} +: 32] <= bus_rdata_i[31:0];
                word_cnt <= word_cnt + 4'd1;
                if (word_cnt == 4'd7) begin
                  state          <= S_DONE;
                  digest_valid_o <= 1'b1;
                  word_cnt       <= 4'd0;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_bus_master.sv
// Directed bench for sha256_bus_master: a register-level slave model answers the bus and
// a scoreboard checks every transaction and every block result.
module tb_sha256_bus_master;

  localparam int          AW   = 64;
  localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;
  localparam int          PLIM = 8;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] MB1_BLK = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
  localparam logic [255:0] MB1_DIG = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [511:0] MB2_BLK = 512'h1c0;
  localparam logic [255:0] MB2_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_first;
  logic [511:0]  cmd_block;
  logic [255:0]  digest;
  logic          dv, err, busy;
  logic          bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [AW-1:0] bus_addr;
  logic [63:0]   bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  sha256_bus_master #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .POLL_LIMIT(PLIM)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_first_i(cmd_first), .cmd_block_i(cmd_block),
    .digest_o(digest), .digest_valid_o(dv), .err_o(err), .busy_o(busy),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
  );

  typedef struct packed { logic we; logic [63:0] addr; logic [63:0] wdata; } tx_t;
  typedef struct packed { logic [255:0] digest; logic err; int polls; int lat; } res_t;

  tx_t  txq[$];
  res_t resq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int           gnt_delay, rv_delay, cfg_zeros;
  logic [255:0] slave_digest;
  logic [255:0] model_digest;
  logic         hold_valid;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave model: grants after gnt_delay cycles, completes rv_delay cycles after the grant.
  int          s_gwait = 0, s_rwait = 0, s_zcnt = 0, s_idx = 0;
  bit          s_pend = 0;
  logic [63:0] s_rdat = 64'd0;

  initial begin
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 64'd0;
    forever begin
      @(posedge clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (s_pend) begin
        if (s_rwait == 0) begin
          bus_rvalid = 1'b1; bus_rdata = s_rdat; s_pend = 0;
        end else s_rwait--;
      end else if (bus_req) begin
        if (s_gwait < gnt_delay) s_gwait++;
        else begin
          s_gwait = 0;
          bus_gnt = 1'b1;
          s_idx   = int'((bus_addr - BASE) >> 3);
          s_rdat  = {$urandom, $urandom};
          if (bus_we) begin
            if (s_idx == 0 && bus_wdata == 64'd0) s_zcnt = 0;
          end else if (s_idx == 17) begin
            s_rdat[0] = (s_zcnt >= cfg_zeros);
            s_zcnt++;
          end else if (s_idx >= 18 && s_idx <= 25) begin
            s_rdat[31:0] = slave_digest[(s_idx - 18) * 32 +: 32];
          end
          if (rv_delay == 0) begin
            bus_rvalid = 1'b1; bus_rdata = s_rdat;
          end else begin
            s_pend = 1; s_rwait = rv_delay - 1;
          end
        end
      end else s_gwait = 0;
    end
  end

  // Monitor: request stability, transaction scoreboard and per-block results.
  bit            m_prev_busy = 0, m_held = 0;
  logic [63:0]   m_h_addr, m_h_wdata;
  logic          m_h_we;
  int            m_polls = 0, m_dv_cnt = 0, m_acc_cyc = 0, m_dv_cyc = 0, done_cnt = 0;
  tx_t           m_t;
  res_t          m_r;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_prev_busy = 0; m_held = 0;
      end else begin
        if (busy && !m_prev_busy) begin
          m_polls = 0; m_dv_cnt = 0; m_acc_cyc = cyc; m_dv_cyc = 0;
        end
        if (m_held) begin
          checkOutput("hold_addr", bus_addr, m_h_addr);
          checkOutput("hold_we", bus_we, m_h_we);
          checkOutput("hold_wdata", bus_wdata, m_h_wdata);
        end
        m_held = bus_req && !bus_gnt;
        m_h_addr = bus_addr; m_h_we = bus_we; m_h_wdata = bus_wdata;
        if (bus_req && bus_gnt) begin
          if (!bus_we && bus_addr == BASE + 64'h88) m_polls++;
          else begin
            checkOutput("tx_expected", txq.size() > 0, 1'b1);
            if (txq.size() > 0) begin
              m_t = txq.pop_front();
              checkOutput("tx_we", bus_we, m_t.we);
              checkOutput("tx_addr", bus_addr, m_t.addr);
              if (m_t.we) checkOutput("tx_wdata", bus_wdata, m_t.wdata);
            end
          end
        end
        if (dv) begin
          m_dv_cnt++;
          if (m_dv_cnt == 1) m_dv_cyc = cyc;
        end
        if (!busy && m_prev_busy) begin
          done_cnt++;
          checkOutput("result_expected", resq.size() > 0, 1'b1);
          if (resq.size() > 0) begin
            m_r = resq.pop_front();
            checkOutput("res_err", err, m_r.err);
            checkOutput("res_digest", digest, m_r.digest);
            checkOutput("res_pulses", m_dv_cnt, m_r.err ? 0 : 1);
            checkOutput("res_polls", m_polls, m_r.polls);
            if (m_r.lat >= 0) checkOutput("res_latency", m_dv_cyc - m_acc_cyc, m_r.lat);
            checkOutput("res_tx_left", txq.size(), 0);
          end
        end
        m_prev_busy = busy;
      end
    end
  end

  task automatic applyStimulus(input logic [511:0] blk, input logic first, input logic [255:0] dig,
                               input int zeros, input int lat);
    res_t r;
    cfg_zeros    = zeros;
    slave_digest = dig;
    for (int k = 0; k < 16; k++)
      txq.push_back('{we: 1'b1, addr: BASE + 64'(8 * (k + 1)), wdata: {32'h0, blk[32 * k +: 32]}});
    txq.push_back('{we: 1'b1, addr: BASE, wdata: first ? 64'h1 : 64'h2});
    txq.push_back('{we: 1'b1, addr: BASE, wdata: 64'h0});
    r.err   = (zeros >= PLIM);
    r.polls = r.err ? PLIM : zeros + 1;
    if (!r.err) begin
      for (int i = 0; i < 8; i++)
        txq.push_back('{we: 1'b0, addr: BASE + 64'(8 * (18 + i)), wdata: 64'h0});
      model_digest = dig;
    end
    r.digest = model_digest;
    r.lat    = lat;
    resq.push_back(r);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_block = blk; cmd_first = first;
    @(posedge clk); #1;
    if (!hold_valid) cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk); n++;
    end
    checkOutput({tag, "_timeout"}, busy, 1'b0);
  endtask

  int   n;
  logic found;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_first = 1'b0; cmd_block = '0; hold_valid = 1'b0;
    gnt_delay = 0; rv_delay = 0; cfg_zeros = 0; slave_digest = '0; model_digest = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", bus_req, 1'b0);
    checkOutput("rst_dv", dv, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ready", cmd_ready, 1'b1);
    checkOutput("rst_digest", digest, 256'h0);
    rst = 1'b0;

    $display("[TB] abc, zero-wait slave");
    applyStimulus(ABC_BLK, 1'b1, ABC_DIG, 0, 53);
    waitIdle("abc", 500);

    $display("[TB] two-block message");
    applyStimulus(MB1_BLK, 1'b1, MB1_DIG, 2, -1);
    waitIdle("mb1", 500);
    applyStimulus(MB2_BLK, 1'b0, MB2_DIG, 2, -1);
    waitIdle("mb2", 500);

    $display("[TB] grant withheld 5 cycles");
    gnt_delay = 5; rv_delay = 1;
    applyStimulus(ABC_BLK, 1'b1, ABC_DIG, 1, -1);
    waitIdle("gnt_delay", 2000);
    gnt_delay = 0; rv_delay = 0;

    $display("[TB] poll timeout");
    applyStimulus(ABC_BLK, 1'b1, ABC_DIG, 1000, -1);
    waitIdle("timeout", 500);
    repeat (3) begin
      @(negedge clk);
      checkOutput("err_sticky", err, 1'b1);
    end
    applyStimulus(ABC_BLK, 1'b0, ABC_DIG, 0, -1);
    checkOutput("err_cleared", err, 1'b0);
    waitIdle("after_err", 500);

    $display("[TB] cmd_valid held high");
    hold_valid = 1'b1;
    applyStimulus(ABC_BLK, 1'b1, ABC_DIG, 0, -1);
    n = 0;
    while (busy && n < 500) begin
      checkOutput("ready_while_busy", cmd_ready, 1'b0);
      @(negedge clk); n++;
    end
    cmd_valid = 1'b0; hold_valid = 1'b0;
    checkOutput("hold_timeout", busy, 1'b0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("no_second_block", busy, 1'b0);
    end

    $display("[TB] reset during third digest read");
    rv_delay = 3;
    applyStimulus(ABC_BLK, 1'b1, ABC_DIG, 1, -1);
    n = 0; found = 1'b0;
    while (!found && n < 2000) begin
      @(negedge clk); n++;
      if (bus_req && bus_gnt && !bus_we && bus_addr == BASE + 64'd160) found = 1'b1;
    end
    checkOutput("rd3_seen", found, 1'b1);
    #1;
    txq.delete(); resq.delete(); model_digest = '0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_req", bus_req, 1'b0);
    checkOutput("mid_rst_ready", cmd_ready, 1'b1);
    checkOutput("mid_rst_err", err, 1'b0);
    checkOutput("mid_rst_digest", digest, 256'h0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput("late_rvalid_busy", busy, 1'b0);
      checkOutput("late_rvalid_dv", dv, 1'b0);
    end
    rv_delay = 0;
    applyStimulus(ABC_BLK, 1'b1, ABC_DIG, 0, 53);
    waitIdle("after_rst", 500);

    @(negedge clk); #1;
    checkOutput("queues_empty", txq.size() + resq.size(), 0);
    checkOutput("blocks_done", done_cnt, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
